// File: rtl/iram_loader.sv
// iram_loader: boot-time program loader.
//   Receives a length-prefixed byte stream (valid/ready). It packs the bytes
//   little-endian into 64-bit words and writes them to the instruction RAM.
//   The core is held in reset until the image has loaded completely.
//   Optional feature macro: LOADER_CHECKSUM_EN. When it is defined, a trailing
//   XOR checksum byte is checked in state CHK.
// Ports:
//   clk_i, rst_n_i    clock, asynchronous active-low reset
//   start_i           begin a load (honoured in IDLE, DONE, ERR)
//   byte_valid_i/byte_data_i/byte_ready_o   host byte stream
//   mem_write_en_o/mem_addr_o/mem_write_data_o   iram write port
//   mem_error_i       iram error for the current mem_addr_o
//   cpu_rst_n_o       core reset, released only in DONE
//   busy_o/done_o/error_o   loader status
module iram_loader #(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        mem_write_en_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_write_data_o,
  input  logic        mem_error_i,
  output logic        cpu_rst_n_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned WORD_W = 64;
  localparam int unsigned IDX_W  = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
`ifdef LOADER_CHECKSUM_EN
    , S_CHK = 3'd7
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] addr_q, addr_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic byte_ready_q, byte_ready_d;
  logic wen_q, wen_d;
  logic cpu_rst_n_q, cpu_rst_n_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic error_q, error_d;

  logic             xfer;
  logic [LEN_W-1:0] len_full;

  assign xfer     = byte_valid_i & byte_ready_q;
  assign len_full = {byte_data_i, len_lo_q};

  // Next-state, datapath and output decode
  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    word_d   = word_q;
    addr_d   = addr_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d = S_LEN0;
          rem_d   = '0;
          idx_d   = '0;
          word_d  = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_LEN0: begin
        if (xfer) begin
          len_lo_d = byte_data_i;
          state_d  = S_LEN1;
        end
      end
      S_LEN1: begin
        if (xfer) begin
          if (len_full == '0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end else if (32'(len_full) > MEM_BYTES) begin
            state_d = S_ERR;
          end else begin
            rem_d   = len_full;
            addr_d  = BASE_ADDR;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          word_d[{idx_q, 3'b000} +: 8] = byte_data_i;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ byte_data_i;
`endif
          rem_d = rem_q - LEN_W'(1);
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(7) || rem_q == LEN_W'(1)) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (mem_error_i) begin
          state_d = S_ERR;
        end else if (rem_q != '0) begin
          // Start a fresh zeroed word so a short tail is zero-padded
          addr_d  = addr_q + WORD_W'(8);
          idx_d   = '0;
          word_d  = '0;
          state_d = S_DATA;
        end else begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) begin
          state_d = (byte_data_i == csum_q) ? S_DONE : S_ERR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the upcoming state
    byte_ready_d = (state_d == S_LEN0) || (state_d == S_LEN1) || (state_d == S_DATA);
`ifdef LOADER_CHECKSUM_EN
    byte_ready_d = byte_ready_d || (state_d == S_CHK);
`endif
    wen_d       = (state_d == S_WRITE);
    cpu_rst_n_d = (state_d == S_DONE);
    done_d      = (state_d == S_DONE);
    error_d     = (state_d == S_ERR);
    busy_d      = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERR));
  end

  // State, datapath and output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      len_lo_q     <= '0;
      rem_q        <= '0;
      idx_q        <= '0;
      word_q       <= '0;
      addr_q       <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
      byte_ready_q <= 1'b0;
      wen_q        <= 1'b0;
      cpu_rst_n_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      rem_q        <= rem_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      addr_q       <= addr_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
      byte_ready_q <= byte_ready_d;
      wen_q        <= wen_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign byte_ready_o     = byte_ready_q;
  assign mem_write_en_o   = wen_q;
  assign mem_addr_o       = addr_q;
  assign mem_write_data_o = word_q;
  assign cpu_rst_n_o      = cpu_rst_n_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign error_o          = error_q;

endmodule
